// File: rtl/csr_trap_seq_pkg.sv
// ----------------------------------------------------------------------------
// csr_trap_seq_pkg
// Shared definitions for the trap-entry / MRET sequencer: CSR addresses,
// mstatus / mtvec field positions, privilege encodings and sequencer states.
// No ports (package).
// ----------------------------------------------------------------------------
package csr_trap_seq_pkg;

    // Machine-mode CSR addresses touched by the sequencer
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus bit positions (MPP occupies MPP_LO+1:MPP_LO)
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_t;

    typedef enum logic [3:0] {
        IDLE,
        RD_MST,
        WR_EPC,
        WR_CAUSE,
        WR_TVAL,
        WR_MST,
        RD_TVEC,
        RD_EPC,
        REDIR
    } trap_state_t;

endpackage

// File: rtl/csr_trap_seq_vec_calc.sv
// ----------------------------------------------------------------------------
// trap_vec_calc
// Purely combinational trap target calculation from mtvec and mcause.
// Direct mode (and reserved modes 2/3) jump to the aligned base; vectored
// mode jumps to base + 4*code for interrupts only.
// Ports:
//   i_mtvec   in  XLEN  latched mtvec value
//   i_irq     in  1     mcause interrupt bit
//   i_code    in  6     mcause low bits used as the vector index
//   o_target  out XLEN  trap entry PC (addition wraps modulo 2^XLEN)
// ----------------------------------------------------------------------------
module trap_vec_calc
    import csr_trap_seq_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int VECTOR_EN = 1
) (
    input  logic [XLEN-1:0] i_mtvec,
    input  logic            i_irq,
    input  logic [5:0]      i_code,
    output logic [XLEN-1:0] o_target
);

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_offset;
    logic            w_vectored;

    assign w_base     = {i_mtvec[XLEN-1:2], 2'b00};
    assign w_offset   = {{(XLEN-8){1'b0}}, i_code, 2'b00};
    assign w_vectored = (VECTOR_EN != 0) && (i_mtvec[1:0] == MTVEC_MODE_VECTORED) && i_irq;
    assign o_target   = w_vectored ? (w_base + w_offset) : w_base;

endmodule

// File: rtl/csr_trap_seq.sv
// ----------------------------------------------------------------------------
// csr_trap_seq
// Trap-entry / MRET sequencer that owns the CSR file write and read ports
// while busy. A trap saves mepc/mcause/mtval, updates mstatus, reads mtvec
// and redirects fetch; MRET restores mstatus and redirects to mepc.
// Ports:
//   clk, rst                      clock, async active-low reset
//   trap_req/cause/pc/tval        trap request and its payload
//   mret_req                      MRET request
//   req_ack                       one-cycle pulse after a request is taken
//   busy                          sequence running, core stalls
//   csr_we/wtarget/wdata          CSR file write port
//   csr_rtarget/rdata             CSR file read port (combinational read)
//   redirect_valid/redirect_pc    fetch redirect pulse and target
//   priv                          current privilege level
// ----------------------------------------------------------------------------
module csr_trap_seq
    import csr_trap_seq_pkg::*;
#(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11,
    parameter int         VECTOR_EN  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    output logic            req_ack,
    output logic            busy,
    output logic            csr_we,
    output logic [11:0]     csr_wtarget,
    output logic [XLEN-1:0] csr_wdata,
    output logic [11:0]     csr_rtarget,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv
);

    trap_state_t     r_state;
    logic            r_is_mret;
    logic            r_busy;
    logic            r_req_ack;
    logic            r_csr_we;
    logic [11:0]     r_wtarget;
    logic [11:0]     r_rtarget;
    logic            r_redirect_valid;
    logic [1:0]      r_priv;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;

    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_redirect_pc;

    // mstatus image written on trap entry: stash MIE and privilege, mask interrupts
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m, input logic [1:0] p);
        logic [XLEN-1:0] v;
        v = m;
        v[MSTATUS_MPIE] = m[MSTATUS_MIE];
        v[MSTATUS_MIE] = 1'b0;
        v[MSTATUS_MPP_LO +: 2] = p;
        return v;
    endfunction

    // mstatus image written on MRET: restore MIE, re-arm MPIE, MPP falls to U
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] v;
        v = m;
        v[MSTATUS_MIE] = m[MSTATUS_MPIE];
        v[MSTATUS_MPIE] = 1'b1;
        v[MSTATUS_MPP_LO +: 2] = PRIV_U;
        return v;
    endfunction

    trap_vec_calc #(
        .XLEN      (XLEN),
        .VECTOR_EN (VECTOR_EN)
    ) u_vec_calc (
        .i_mtvec  (r_mtvec),
        .i_irq    (r_cause[XLEN-1]),
        .i_code   (r_cause[5:0]),
        .o_target (w_target)
    );

    // Control outputs are registered on the transition into each state, so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_is_mret        <= 1'b0;
            r_busy           <= 1'b0;
            r_req_ack        <= 1'b0;
            r_csr_we         <= 1'b0;
            r_wtarget        <= '0;
            r_rtarget        <= '0;
            r_redirect_valid <= 1'b0;
            r_priv           <= RESET_PRIV;
            r_cause          <= '0;
            r_pc             <= '0;
            r_tval           <= '0;
            r_mstatus        <= '0;
            r_mtvec          <= '0;
            r_mepc           <= '0;
        end else begin
            r_req_ack        <= 1'b0;
            r_redirect_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // trap wins when both requests arrive together
                    if (trap_req || mret_req) begin
                        r_state   <= RD_MST;
                        r_is_mret <= !trap_req;
                        r_busy    <= 1'b1;
                        r_req_ack <= 1'b1;
                        r_rtarget <= CSR_MSTATUS;
                        if (trap_req) begin
                            r_cause <= trap_cause;
                            r_pc    <= trap_pc;
                            r_tval  <= trap_tval;
                        end
                    end
                end
                RD_MST: begin
                    r_mstatus <= csr_rdata;
                    r_rtarget <= '0;
                    r_csr_we  <= 1'b1;
                    if (r_is_mret) begin
                        r_state   <= WR_MST;
                        r_wtarget <= CSR_MSTATUS;
                    end else begin
                        r_state   <= WR_EPC;
                        r_wtarget <= CSR_MEPC;
                    end
                end
                WR_EPC: begin
                    r_state   <= WR_CAUSE;
                    r_wtarget <= CSR_MCAUSE;
                end
                WR_CAUSE: begin
                    r_state   <= WR_TVAL;
                    r_wtarget <= CSR_MTVAL;
                end
                WR_TVAL: begin
                    r_state   <= WR_MST;
                    r_wtarget <= CSR_MSTATUS;
                end
                WR_MST: begin
                    r_csr_we  <= 1'b0;
                    r_wtarget <= '0;
                    if (r_is_mret) begin
                        r_state   <= RD_EPC;
                        r_rtarget <= CSR_MEPC;
                        r_priv    <= r_mstatus[MSTATUS_MPP_LO +: 2];
                    end else begin
                        r_state   <= RD_TVEC;
                        r_rtarget <= CSR_MTVEC;
                        r_priv    <= PRIV_M;
                    end
                end
                RD_TVEC: begin
                    r_mtvec          <= csr_rdata;
                    r_rtarget        <= '0;
                    r_state          <= REDIR;
                    r_redirect_valid <= 1'b1;
                end
                RD_EPC: begin
                    r_mepc           <= csr_rdata;
                    r_rtarget        <= '0;
                    r_state          <= REDIR;
                    r_redirect_valid <= 1'b1;
                end
                REDIR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write data comes only from latched registers; the CSR file commits on
    // the falling edge, so same-cycle read data must never feed it.
    always_comb begin
        w_wdata = '0;
        case (r_state)
            WR_EPC:   w_wdata = r_pc;
            WR_CAUSE: w_wdata = r_cause;
            WR_TVAL:  w_wdata = r_tval;
            WR_MST:   w_wdata = r_is_mret ? mret_mstatus(r_mstatus) : trap_mstatus(r_mstatus, r_priv);
            default:  w_wdata = '0;
        endcase
    end

    always_comb begin
        w_redirect_pc = '0;
        if (r_state == REDIR) begin
            w_redirect_pc = r_is_mret ? r_mepc : w_target;
        end
    end

    assign busy           = r_busy;
    assign req_ack        = r_req_ack;
    assign csr_we         = r_csr_we;
    assign csr_wtarget    = r_wtarget;
    assign csr_wdata      = w_wdata;
    assign csr_rtarget    = r_rtarget;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = w_redirect_pc;
    assign priv           = r_priv;

endmodule

// File: tb/tb_csr_trap_seq.sv
// ----------------------------------------------------------------------------
// tb_csr_trap_seq
// Drives two sequencers (vectoring enabled and disabled) from the same
// stimulus, each attached to its own small CSR file model, and compares
// every cycle against a behavioural model of the trap / MRET rules.
// ----------------------------------------------------------------------------
module tb_csr_trap_seq;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic        clk = 1'b0;
    logic        rst;
    logic        trapReq;
    logic [63:0] trapCause;
    logic [63:0] trapPc;
    logic [63:0] trapTval;
    logic        mretReq;

    logic        reqAckV, busyV, csrWeV, redirectValidV;
    logic [11:0] csrWtargetV, csrRtargetV;
    logic [63:0] csrWdataV, csrRdataV, redirectPcV;
    logic [1:0]  privV;

    logic        reqAckN, busyN, csrWeN, redirectValidN;
    logic [11:0] csrWtargetN, csrRtargetN;
    logic [63:0] csrWdataN, csrRdataN, redirectPcN;
    logic [1:0]  privN;

    logic        tbWe;
    logic [11:0] tbAddr;
    logic [63:0] tbData;
    logic [63:0] csrMem [2][6];

    logic [63:0] mMst, mEpc, mCause, mTval, mTvec;
    logic [1:0]  mPriv;

    int checks = 0;
    int errors = 0;

    csr_trap_seq #(.XLEN(64), .RESET_PRIV(2'b11), .VECTOR_EN(1)) dut (
        .clk(clk), .rst(rst), .trap_req(trapReq), .trap_cause(trapCause), .trap_pc(trapPc),
        .trap_tval(trapTval), .mret_req(mretReq), .req_ack(reqAckV), .busy(busyV),
        .csr_we(csrWeV), .csr_wtarget(csrWtargetV), .csr_wdata(csrWdataV),
        .csr_rtarget(csrRtargetV), .csr_rdata(csrRdataV), .redirect_valid(redirectValidV),
        .redirect_pc(redirectPcV), .priv(privV)
    );

    csr_trap_seq #(.XLEN(64), .RESET_PRIV(2'b11), .VECTOR_EN(0)) dutNv (
        .clk(clk), .rst(rst), .trap_req(trapReq), .trap_cause(trapCause), .trap_pc(trapPc),
        .trap_tval(trapTval), .mret_req(mretReq), .req_ack(reqAckN), .busy(busyN),
        .csr_we(csrWeN), .csr_wtarget(csrWtargetN), .csr_wdata(csrWdataN),
        .csr_rtarget(csrRtargetN), .csr_rdata(csrRdataN), .redirect_valid(redirectValidN),
        .redirect_pc(redirectPcN), .priv(privN)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    function automatic int csrIdx(input logic [11:0] a);
        case (a)
            A_MSTATUS: return 0;
            A_MEPC:    return 1;
            A_MCAUSE:  return 2;
            A_MTVAL:   return 3;
            A_MTVEC:   return 4;
            default:   return 5;
        endcase
    endfunction

    // CSR file models: commit on the falling edge, sequencer has priority
    always @(negedge clk) begin
        if (csrWeV) csrMem[0][csrIdx(csrWtargetV)] <= csrWdataV;
        else if (tbWe) csrMem[0][csrIdx(tbAddr)] <= tbData;
        if (csrWeN) csrMem[1][csrIdx(csrWtargetN)] <= csrWdataN;
        else if (tbWe) csrMem[1][csrIdx(tbAddr)] <= tbData;
    end

    assign csrRdataV = csrMem[0][csrIdx(csrRtargetV)];
    assign csrRdataN = csrMem[1][csrIdx(csrRtargetN)];

    // Hard stop in case the run ever wanders off
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference rules for mstatus and trap target, written as plain masks and arithmetic
    function automatic logic [63:0] trapMst(input logic [63:0] m, input logic [1:0] p);
        return (m & ~64'h1888) | ({63'd0, m[3]} << 7) | ({62'd0, p} << 11);
    endfunction

    function automatic logic [63:0] mretMst(input logic [63:0] m);
        return (m & ~64'h1888) | ({63'd0, m[7]} << 3) | 64'h80;
    endfunction

    function automatic logic [63:0] vecTarget(input logic [63:0] tvec, input logic [63:0] cause, input bit vec);
        logic [63:0] base;
        base = tvec & ~64'h3;
        if (vec && (tvec % 4 == 1) && cause[63]) return base + (cause % 64) * 4;
        return base;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic t, input logic m, input logic [63:0] c,
                                 input logic [63:0] p, input logic [63:0] v);
        trapReq   = t;
        mretReq   = m;
        trapCause = c;
        trapPc    = p;
        trapTval  = v;
    endtask

    task automatic setCsr(input logic [11:0] a, input logic [63:0] d);
        tbWe   = 1'b1;
        tbAddr = a;
        tbData = d;
        tick();
        tbWe = 1'b0;
        case (a)
            A_MSTATUS: mMst  = d;
            A_MEPC:    mEpc  = d;
            A_MCAUSE:  mCause = d;
            A_MTVAL:   mTval = d;
            default:   mTvec = d;
        endcase
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, " busy"}, {63'd0, busyV}, 64'd0);
        checkOutput({pfx, " ack"}, {63'd0, reqAckV}, 64'd0);
        checkOutput({pfx, " we"}, {63'd0, csrWeV}, 64'd0);
        checkOutput({pfx, " wt"}, {52'd0, csrWtargetV}, 64'd0);
        checkOutput({pfx, " wd"}, csrWdataV, 64'd0);
        checkOutput({pfx, " rt"}, {52'd0, csrRtargetV}, 64'd0);
        checkOutput({pfx, " rv"}, {63'd0, redirectValidV}, 64'd0);
        checkOutput({pfx, " rpc"}, redirectPcV, 64'd0);
        checkOutput({pfx, " priv"}, {62'd0, privV}, 64'd3);
        checkOutput({pfx, " nv busy"}, {63'd0, busyN}, 64'd0);
    endtask

    task automatic checkCycle(input string pfx, input int k, input logic eBusy, input logic eAck,
                              input logic eWe, input logic [11:0] eWt, input logic [63:0] eWd,
                              input logic [11:0] eRt, input logic eRv, input logic [63:0] eRpcV,
                              input logic [63:0] eRpcN, input logic [1:0] ePriv);
        string t;
        t = $sformatf("%s k%0d", pfx, k);
        checkOutput({t, " busy"}, {63'd0, busyV}, {63'd0, eBusy});
        checkOutput({t, " ack"}, {63'd0, reqAckV}, {63'd0, eAck});
        checkOutput({t, " we"}, {63'd0, csrWeV}, {63'd0, eWe});
        checkOutput({t, " wt"}, {52'd0, csrWtargetV}, {52'd0, eWt});
        if (eWe) checkOutput({t, " wd"}, csrWdataV, eWd);
        checkOutput({t, " rt"}, {52'd0, csrRtargetV}, {52'd0, eRt});
        checkOutput({t, " rv"}, {63'd0, redirectValidV}, {63'd0, eRv});
        if (eRv) checkOutput({t, " rpc"}, redirectPcV, eRpcV);
        checkOutput({t, " priv"}, {62'd0, privV}, {62'd0, ePriv});
        checkOutput({t, " nv busy"}, {63'd0, busyN}, {63'd0, eBusy});
        checkOutput({t, " nv rv"}, {63'd0, redirectValidN}, {63'd0, eRv});
        if (eRv) checkOutput({t, " nv rpc"}, redirectPcN, eRpcN);
        checkOutput({t, " nv priv"}, {62'd0, privN}, {62'd0, ePriv});
    endtask

    task automatic checkCsrs(input string pfx);
        checkOutput({pfx, " mstatus"}, csrMem[0][0], mMst);
        checkOutput({pfx, " mepc"}, csrMem[0][1], mEpc);
        checkOutput({pfx, " mcause"}, csrMem[0][2], mCause);
        checkOutput({pfx, " mtval"}, csrMem[0][3], mTval);
        checkOutput({pfx, " nv mstatus"}, csrMem[1][0], mMst);
    endtask

    // Trap entry: request lands at the end of cycle N, k counts cycles after it
    task automatic doTrap(input string pfx, input logic [63:0] c, input logic [63:0] p,
                          input logic [63:0] v, input logic bothReq, input logic mretBusy,
                          output logic [63:0] rpcV, output logic [63:0] rpcN);
        logic [63:0] newMst, tgtV, tgtN, eWd;
        logic [11:0] eWt, eRt;
        logic [1:0]  p0;
        p0     = mPriv;
        newMst = trapMst(mMst, p0);
        tgtV   = vecTarget(mTvec, c, 1'b1);
        tgtN   = vecTarget(mTvec, c, 1'b0);
        rpcV   = '0;
        rpcN   = '0;
        applyStimulus(1'b1, bothReq, c, p, v);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) applyStimulus(1'b0, mretBusy, 64'd0, 64'd0, 64'd0);
            if (k == 7) mretReq = 1'b0;
            case (k)
                2: begin eWt = A_MEPC;    eWd = p;      end
                3: begin eWt = A_MCAUSE;  eWd = c;      end
                4: begin eWt = A_MTVAL;   eWd = v;      end
                5: begin eWt = A_MSTATUS; eWd = newMst; end
                default: begin eWt = 12'd0; eWd = 64'd0; end
            endcase
            eRt = (k == 1) ? A_MSTATUS : ((k == 6) ? A_MTVEC : 12'd0);
            if (k == 7) begin
                rpcV = redirectPcV;
                rpcN = redirectPcN;
            end
            checkCycle(pfx, k, k <= 7, k == 1, (k >= 2) && (k <= 5), eWt, eWd, eRt, k == 7,
                       tgtV, tgtN, (k >= 6) ? 2'b11 : p0);
        end
        mEpc   = p;
        mCause = c;
        mTval  = v;
        mMst   = newMst;
        mPriv  = 2'b11;
        if (mretBusy) begin
            tick();
            checkOutput({pfx, " mret not queued"}, {63'd0, busyV}, 64'd0);
        end
        checkCsrs(pfx);
    endtask

    // MRET: four busy cycles, redirect to the saved mepc in the last one
    task automatic doMret(input string pfx);
        logic [63:0] newMst, epc;
        logic [1:0]  p0, newPriv;
        p0      = mPriv;
        newMst  = mretMst(mMst);
        newPriv = mMst[12:11];
        epc     = mEpc;
        applyStimulus(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) mretReq = 1'b0;
            checkCycle(pfx, k, k <= 4, k == 1, k == 2, (k == 2) ? A_MSTATUS : 12'd0, newMst,
                       (k == 1) ? A_MSTATUS : ((k == 3) ? A_MEPC : 12'd0), k == 4, epc, epc,
                       (k >= 3) ? newPriv : p0);
        end
        mMst  = newMst;
        mPriv = newPriv;
        checkCsrs(pfx);
    endtask

    // Reset asserted in the middle of WR_CAUSE: MEPC already committed, the rest never happens
    task automatic doResetMid();
        logic [63:0] causeBefore, tvalBefore, pc;
        causeBefore = mCause;
        tvalBefore  = mTval;
        pc          = 64'h8000_2000;
        applyStimulus(1'b1, 1'b0, 64'd5, pc, 64'h1234);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        tick();
        tick();
        checkOutput("rstmid pre we", {63'd0, csrWeV}, 64'd1);
        checkOutput("rstmid pre wt", {52'd0, csrWtargetV}, {52'd0, A_MCAUSE});
        #1 rst = 1'b0;
        #1 checkAllZero("rstmid async");
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("rstmid post%0d rv", k), {63'd0, redirectValidV}, 64'd0);
            checkOutput($sformatf("rstmid post%0d busy", k), {63'd0, busyV}, 64'd0);
        end
        mEpc  = pc;
        mPriv = 2'b11;
        checkOutput("rstmid mepc", csrMem[0][1], pc);
        checkOutput("rstmid mcause", csrMem[0][2], causeBefore);
        checkOutput("rstmid mtval", csrMem[0][3], tvalBefore);
        checkOutput("rstmid priv", {62'd0, privV}, 64'd3);
    endtask

    // Directed spec scenarios first, then a randomized mix of traps and MRETs
    initial begin
        logic [63:0] rpcV, rpcN;
        logic [63:0] c;
        rst   = 1'b0;
        tbWe  = 1'b0;
        tbAddr = '0;
        tbData = '0;
        mPriv = 2'b11;
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        tick();
        setCsr(A_MSTATUS, 64'd0);
        setCsr(A_MEPC, 64'd0);
        setCsr(A_MCAUSE, 64'd0);
        setCsr(A_MTVAL, 64'd0);
        setCsr(A_MTVEC, 64'd0);
        checkAllZero("reset");
        rst = 1'b1;
        tick();
        checkAllZero("after reset");

        setCsr(A_MTVEC, 64'h8000_0000);
        setCsr(A_MSTATUS, 64'h8);
        doTrap("direct", 64'd2, 64'h8000_1000, 64'hDEAD, 1'b0, 1'b0, rpcV, rpcN);
        checkOutput("direct rpc", rpcV, 64'h8000_0000);
        checkOutput("direct priv", {62'd0, privV}, 64'd3);

        setCsr(A_MTVEC, 64'h8000_0001);
        doTrap("vectored", 64'h8000_0000_0000_0007, 64'h8000_1100, 64'h42, 1'b1, 1'b1, rpcV, rpcN);
        checkOutput("vectored rpc", rpcV, 64'h8000_001C);
        checkOutput("vectored off rpc", rpcN, 64'h8000_0000);

        setCsr(A_MTVEC, 64'hFFFF_FFFF_FFFF_FFF1);
        doTrap("wrap", 64'h8000_0000_0000_003F, 64'h10, 64'h20, 1'b0, 1'b0, rpcV, rpcN);
        checkOutput("wrap rpc", rpcV, 64'h0000_0000_0000_00EC);

        setCsr(A_MSTATUS, 64'h80);
        setCsr(A_MEPC, 64'h8000_1004);
        doMret("mret");
        checkOutput("mret priv", {62'd0, privV}, 64'd0);
        checkOutput("mret mstatus", csrMem[0][0], 64'h88);

        setCsr(A_MTVEC, 64'h8000_0000);
        doTrap("round trap", 64'd11, 64'h8000_3000, 64'd0, 1'b0, 1'b0, rpcV, rpcN);
        doMret("round mret");
        checkOutput("round priv", {62'd0, privV}, 64'd0);
        checkOutput("round mstatus", csrMem[0][0], 64'h88);

        doResetMid();

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 9))
                0, 1: setCsr(A_MTVEC, rnd64());
                2: setCsr(A_MSTATUS, rnd64());
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                c = rnd64();
                doTrap($sformatf("rnd%0d trap", i), c, rnd64(), rnd64(),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rpcV, rpcN);
            end else begin
                doMret($sformatf("rnd%0d mret", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
